// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   DEFAULT_NOP_INSTR : bubble encoding (addi x0,x0,0)
//   DEFAULT_RESET_PC  : boot vector loaded into the PC on reset
//   fetch_state_t     : fetch stage control state
package cpu_pkg;

   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'hBFC0_0000;

   typedef enum logic [0:0] {
      RUN,
      FAULT
   } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Stall hold buffer for the fetch stage.
// The ROM keeps returning data for the current PC while the stage is stalled, so the word
// that belongs to the outstanding request is captured here on the first stalled cycle and
// replayed when the stall releases.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   capture_i     stalled cycle with an outstanding request
//   clear_i       buffer contents consumed or discarded this cycle
//   imem_rd_i     ROM read data
//   hold_valid_o  buffer holds a captured word
//   instr_o       held word if valid, otherwise live ROM data
module fetch_hold_buf
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        capture_i,
   input  logic        clear_i,
   input  logic [31:0] imem_rd_i,
   output logic        hold_valid_o,
   output logic [31:0] instr_o
);

   logic [31:0] hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (clear_i) begin
         hold_valid_d = 1'b0;
      end else if (capture_i && !hold_valid_q) begin
         // Only the first stalled cycle sees the requested word on imem_rd_i.
         hold_d       = imem_rd_i;
         hold_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q       <= 32'h0;
         hold_valid_q <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   assign hold_valid_o = hold_valid_q;
   assign instr_o      = hold_valid_q ? hold_q : imem_rd_i;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the immediate sign-extension stage.
// Owns the PC, drives a synchronous 1-cycle-latency instruction ROM and holds the IF/ID
// register. Supports stall, flush and redirect (target = base + ImmOp, bit 0 cleared for
// jalr). A redirect to a non-word-aligned target parks the stage in FAULT until reset.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall_i, flush_i         hold PC and IF/ID / bubble the next IF/ID load
//   redirect_i, jalr_i       load PC with target (implies flush) / clear target[0]
//   redirect_base_i, ImmOp   target operands
//   imem_addr_o, imem_rd_i   ROM address (= PC) and data for last cycle's address
//   instr_o, instr_imm_o     IF/ID instruction and its [31:7] immediate field
//   pc_o, pc_plus4_o         IF/ID PC and PC + 4
//   valid_o, fault_o         IF/ID holds a real instruction / sticky misaligned redirect
//   fetch_count_o            number of valid IF/ID loads (wraps)
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = cpu_pkg::DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = cpu_pkg::DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        redirect_i,
   input  logic        jalr_i,
   input  logic [31:0] redirect_base_i,
   input  logic [31:0] ImmOp,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rd_i,
   output logic [31:0] instr_o,
   output logic [24:0] instr_imm_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o,
   output logic        fault_o,
   output logic [31:0] fetch_count_o
);

   fetch_state_t state_q, state_d;

   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;

   logic [31:0] target;
   logic        hold_capture;
   logic        hold_clear;
   logic        hold_valid;
   logic [31:0] sel_instr;

   fetch_hold_buf u_hold_buf (
      .clk          (clk),
      .rst          (rst),
      .capture_i    (hold_capture),
      .clear_i      (hold_clear),
      .imem_rd_i    (imem_rd_i),
      .hold_valid_o (hold_valid),
      .instr_o      (sel_instr)
   );

   always_comb begin
      target = redirect_base_i + ImmOp;
      if (jalr_i) begin
         target[0] = 1'b0;
      end

      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      req_valid_d  = req_valid_q;
      instr_d      = instr_q;
      pc_id_d      = pc_id_q;
      valid_d      = valid_q;
      count_d      = count_q;
      hold_capture = 1'b0;
      hold_clear   = 1'b0;

      unique case (state_q)
         RUN: begin
            if (redirect_i) begin
               // Drop everything in flight; a misaligned target freezes the PC instead.
               hold_clear  = 1'b1;
               req_valid_d = 1'b0;
               instr_d     = NOP_INSTR;
               valid_d     = 1'b0;
               if (target[1]) begin
                  state_d = FAULT;
               end else begin
                  pc_d = target;
               end
            end else begin
               if (stall_i) begin
                  hold_capture = req_valid_q;
               end else begin
                  hold_clear  = 1'b1;
                  pc_d        = pc_q + 32'd4;
                  req_pc_d    = pc_q;
                  req_valid_d = 1'b1;
                  instr_d     = sel_instr;
                  pc_id_d     = req_pc_q;
                  valid_d     = req_valid_q;
                  if (req_valid_q) begin
                     count_d = count_q + 32'd1;
                  end
               end
               // Flush only replaces what IF/ID would have loaded; pipeline state advances.
               if (flush_i) begin
                  instr_d = NOP_INSTR;
                  pc_id_d = pc_id_q;
                  valid_d = 1'b0;
                  count_d = count_q;
               end
            end
         end
         FAULT: begin
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         req_pc_q    <= 32'h0;
         req_valid_q <= 1'b0;
         instr_q     <= NOP_INSTR;
         pc_id_q     <= 32'h0;
         valid_q     <= 1'b0;
         count_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
         instr_q     <= instr_d;
         pc_id_q     <= pc_id_d;
         valid_q     <= valid_d;
         count_q     <= count_d;
      end
   end

   assign imem_addr_o   = pc_q;
   assign instr_o       = instr_q;
   assign instr_imm_o   = instr_q[31:7];
   assign pc_o          = pc_id_q;
   assign pc_plus4_o    = pc_id_q + 32'd4;
   assign valid_o       = valid_q;
   assign fault_o       = (state_q == FAULT);
   assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized stall/flush/redirect
// traffic, every cycle compared against a transaction-level model of the fetch stream.
module tb_fetch_stage;
   import cpu_pkg::*;

   localparam logic [31:0] RPC = 32'hBFC0_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i, redirect_i, jalr_i;
   logic [31:0] redirect_base_i, ImmOp;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rd_i;
   logic [31:0] instr_o;
   logic [24:0] instr_imm_o;
   logic [31:0] pc_o, pc_plus4_o;
   logic        valid_o, fault_o;
   logic [31:0] fetch_count_o;

   fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .redirect_i      (redirect_i),
      .jalr_i          (jalr_i),
      .redirect_base_i (redirect_base_i),
      .ImmOp           (ImmOp),
      .imem_addr_o     (imem_addr_o),
      .imem_rd_i       (imem_rd_i),
      .instr_o         (instr_o),
      .instr_imm_o     (instr_imm_o),
      .pc_o            (pc_o),
      .pc_plus4_o      (pc_plus4_o),
      .valid_o         (valid_o),
      .fault_o         (fault_o),
      .fetch_count_o   (fetch_count_o)
   );

   always #5 clk = ~clk;

   // ROM contents derived from the address so every fetched word is distinct.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   always @(posedge clk) imem_rd_i <= rom(imem_addr_o);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: next address to fetch, one address whose word is on its way, and the IF/ID view.
   logic [31:0] m_pc;
   bit          pend_v;
   logic [31:0] pend_a;
   logic [31:0] e_instr, e_pc, e_count;
   bit          e_instr_k, e_pc_k, e_valid, e_fault;

   task automatic model_reset();
      m_pc      = RPC;
      pend_v    = 0;
      pend_a    = 32'h0;
      e_instr   = NOP;
      e_instr_k = 1;
      e_pc      = 32'h0;
      e_pc_k    = 1;
      e_valid   = 0;
      e_count   = 32'h0;
      e_fault   = 0;
   endtask

   task automatic model_step(input bit st, input bit fl, input bit rd, input bit jr,
                             input logic [31:0] base, input logic [31:0] imm);
      logic [31:0] t;
      bit          d_v;
      logic [31:0] d_a;
      if (e_fault) return;
      if (rd) begin
         t = base + imm;
         if (jr) t = t & 32'hFFFF_FFFE;
         pend_v    = 0;
         e_instr   = NOP;
         e_instr_k = 1;
         e_valid   = 0;
         if ((t % 4) >= 2) e_fault = 1;
         else m_pc = t;
         return;
      end
      d_v = 0;
      d_a = 32'h0;
      if (!st) begin
         d_v    = pend_v;
         d_a    = pend_a;
         pend_v = 1;
         pend_a = m_pc;
         m_pc   = m_pc + 32'd4;
      end
      if (fl) begin
         e_instr   = NOP;
         e_instr_k = 1;
         e_valid   = 0;
      end else if (!st) begin
         if (d_v) begin
            e_instr   = rom(d_a);
            e_instr_k = 1;
            e_pc      = d_a;
            e_pc_k    = 1;
            e_valid   = 1;
            e_count   = e_count + 32'd1;
         end else begin
            e_valid   = 0;
            e_instr_k = 0;
            e_pc_k    = 0;
         end
      end
   endtask

   task automatic check_all();
      logic [31:0] imm_exp;
      check_eq("imem_addr", imem_addr_o, m_pc);
      check_eq("valid", {31'h0, valid_o}, {31'h0, e_valid});
      check_eq("fault", {31'h0, fault_o}, {31'h0, e_fault});
      check_eq("fetch_count", fetch_count_o, e_count);
      if (e_instr_k) begin
         imm_exp = {7'h0, e_instr[31:7]};
         check_eq("instr", instr_o, e_instr);
         check_eq("instr_imm", {7'h0, instr_imm_o}, imm_exp);
      end
      if (e_pc_k) begin
         check_eq("pc", pc_o, e_pc);
         check_eq("pc_plus4", pc_plus4_o, e_pc + 32'd4);
      end
   endtask

   task automatic cycle(input bit st, input bit fl, input bit rd, input bit jr,
                        input logic [31:0] base, input logic [31:0] imm);
      stall_i         = st;
      flush_i         = fl;
      redirect_i      = rd;
      jalr_i          = jr;
      redirect_base_i = base;
      ImmOp           = imm;
      model_step(st, fl, rd, jr, base, imm);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   // Reset is asserted between clock edges so its asynchronous effect is observed directly.
   task automatic do_reset();
      rst        = 1'b1;
      stall_i    = 1'b0;
      flush_i    = 1'b0;
      redirect_i = 1'b0;
      jalr_i     = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();
   endtask

   initial begin
      logic [31:0] base, imm;
      bit          st, fl, rd, jr;
      int          fault_cycles;

      redirect_base_i = 32'h0;
      ImmOp           = 32'h0;
      do_reset();

      // First valid instruction two cycles after reset release.
      idle(2);
      check_eq("first_pc", pc_o, RPC);
      check_eq("first_instr", instr_o, rom(RPC));
      check_eq("first_valid", {31'h0, valid_o}, 32'h1);
      idle(2);
      check_eq("pre_stall_pc", pc_o, 32'hBFC0_0008);

      // Three stalled cycles, then the stream resumes without gap or duplicate.
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 32'h0, 32'h0);
      idle(1);
      check_eq("post_stall_pc0", pc_o, 32'hBFC0_000C);
      idle(1);
      check_eq("post_stall_pc1", pc_o, 32'hBFC0_0010);

      // Backward branch: two bubbles then the target.
      cycle(0, 0, 1, 0, 32'hBFC0_0010, 32'hFFFF_FFF8);
      idle(1);
      check_eq("redir_bubble", {31'h0, valid_o}, 32'h0);
      idle(1);
      check_eq("redir_pc", pc_o, 32'hBFC0_0008);

      // Flush during stall: bubble now, held word still delivered after release.
      idle(2);
      cycle(1, 0, 0, 0, 32'h0, 32'h0);
      cycle(1, 1, 0, 0, 32'h0, 32'h0);
      check_eq("flush_stall_valid", {31'h0, valid_o}, 32'h0);
      idle(3);

      // PC wraps from FFFF_FFFC to 0.
      cycle(0, 0, 1, 0, 32'hFFFF_FFF0, 32'h0000_000C);
      idle(2);
      check_eq("wrap_pc_hi", pc_o, 32'hFFFF_FFFC);
      idle(1);
      check_eq("wrap_pc_lo", pc_o, 32'h0000_0000);
      check_eq("wrap_pc_plus4", pc_plus4_o, 32'h0000_0004);

      // jalr to a halfword address: sticky fault, inputs ignored.
      cycle(0, 0, 1, 1, 32'h0000_1003, 32'h0);
      check_eq("jalr_fault", {31'h0, fault_o}, 32'h1);
      for (int i = 0; i < 6; i++) cycle(i[0], i[1], 1, 0, 32'h100, 32'h0);
      do_reset();

      // Reset in the middle of a stall.
      idle(3);
      cycle(1, 0, 0, 0, 32'h0, 32'h0);
      cycle(1, 0, 0, 0, 32'h0, 32'h0);
      do_reset();

      // Randomized traffic.
      fault_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
         st   = ($urandom_range(0, 3) == 0);
         fl   = ($urandom_range(0, 9) == 0);
         rd   = ($urandom_range(0, 19) == 0);
         jr   = ($urandom_range(0, 1) == 1);
         base = $urandom;
         base[1:0] = jr ? 2'b01 : 2'b00;
         imm  = $urandom;
         imm[1:0] = 2'b00;
         if ($urandom_range(0, 199) == 0) imm[1] = 1'b1;
         cycle(st, fl, rd, jr, base, imm);
         if (e_fault) fault_cycles++;
         if (fault_cycles > 10) begin
            fault_cycles = 0;
            do_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
